// File: rtl/snake_body_buffer_if.sv
// Handshake and read-port bundle between the snake body buffer, the movement logic and the draw FSM.
interface snake_body_buffer_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int LW = 5
);
  logic          init;
  logic          step;
  logic          grow;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] rd_idx;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic          collide;

  modport master (
    output init, step, grow, head_x, head_y, rd_idx,
    input  rd_x, rd_y, length, busy, done, collide
  );

  modport slave (
    input  init, step, grow, head_x, head_y, rd_idx,
    output rd_x, rd_y, length, busy, done, collide
  );
endinterface

// File: rtl/snake_body_buffer.sv
// Snake body segment store: shift-on-step, registered random read, post-step self-collision scan.
// Define SNAKE_SELF_COLLIDE_EN to build the scan FSM and comparator; otherwise done pulses one cycle after each step.
module snake_body_buffer #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int X0       = 39,
  parameter int Y0       = 59,
  parameter int XSTEP    = 10,
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  snake_body_buffer_if.slave bus
);

  // Array address width; LW is one bit wider so length can hold MAX_LEN itself.
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_d;
  logic [XW-1:0] rd_x_q;
  logic [XW-1:0] rd_x_d;
  logic [YW-1:0] rd_y_q;
  logic [YW-1:0] rd_y_d;
  logic          step_accept;

  function automatic logic [XW-1:0] init_x(input int i);
    logic [XW-1:0] v;
    if (i < INIT_LEN) begin
      v = XW'(X0 - i * XSTEP);
    end else begin
      v = {XW{1'b0}};
    end
    return v;
  endfunction

  function automatic logic [YW-1:0] init_y(input int i);
    logic [YW-1:0] v;
    if (i < INIT_LEN) begin
      v = YW'(Y0);
    end else begin
      v = {YW{1'b0}};
    end
    return v;
  endfunction

  // Next segment contents and length for an accepted step.
  always_comb begin
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    len_d   = len_q;
    if (step_accept) begin
      seg_x_d[0] = bus.head_x;
      seg_y_d[0] = bus.head_y;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_d[i] = seg_x_q[i-1];
        seg_y_d[i] = seg_y_q[i-1];
      end
      if (bus.grow && (len_q < LW'(MAX_LEN))) begin
        len_d = len_q + LW'(1);
      end else begin
        len_d = len_q;
      end
    end else begin
      len_d = len_q;
    end
  end

  // Read mux: indices past the live length read as the origin.
  always_comb begin
    rd_x_d = {XW{1'b0}};
    rd_y_d = {YW{1'b0}};
    if (bus.rd_idx < len_q) begin
      rd_x_d = seg_x_q[bus.rd_idx[AW-1:0]];
      rd_y_d = seg_y_q[bus.rd_idx[AW-1:0]];
    end else begin
      rd_x_d = {XW{1'b0}};
      rd_y_d = {YW{1'b0}};
    end
  end

  // Segment storage, length and read registers; init reloads the same layout as reset.
  always_ff @(posedge clk) begin
    if (reset || bus.init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= init_y(i);
      end
      len_q  <= LW'(INIT_LEN);
      rd_x_q <= {XW{1'b0}};
      rd_y_q <= {YW{1'b0}};
    end else begin
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
      len_q   <= len_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
    end
  end

  assign bus.rd_x   = rd_x_q;
  assign bus.rd_y   = rd_y_q;
  assign bus.length = len_q;

`ifdef SNAKE_SELF_COLLIDE_EN

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [LW-1:0] idx_q;
  logic [LW-1:0] idx_d;
  logic          coll_q;
  logic          coll_d;
  logic          seg_hit;

  assign step_accept = bus.step && !bus.init && (state_q == ST_IDLE);
  assign seg_hit     = (seg_x_q[idx_q[AW-1:0]] == seg_x_q[0]) &&
                       (seg_y_q[idx_q[AW-1:0]] == seg_y_q[0]);

  // Scan sequencing: compare body index idx against the head, one index per cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    coll_d  = coll_q;
    case (state_q)
      ST_IDLE: begin
        if (step_accept) begin
          coll_d = 1'b0;
          idx_d  = LW'(1);
          if (len_d == LW'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SCAN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (seg_hit) begin
          coll_d = 1'b1;
        end else begin
          coll_d = coll_q;
        end
        idx_d = idx_q + LW'(1);
        if (idx_q == (len_q - LW'(1))) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {LW{1'b0}};
        coll_d  = 1'b0;
      end
    endcase
  end

  // Scan state register; init aborts any scan without a done pulse.
  always_ff @(posedge clk) begin
    if (reset || bus.init) begin
      state_q <= ST_IDLE;
      idx_q   <= {LW{1'b0}};
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      coll_q  <= coll_d;
    end
  end

  assign bus.busy    = (state_q == ST_SCAN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.collide = coll_q;

`else

  logic done_q;

  assign step_accept = bus.step && !bus.init;

  // Without the scan every step completes on the next cycle.
  always_ff @(posedge clk) begin
    if (reset || bus.init) begin
      done_q <= 1'b0;
    end else begin
      done_q <= step_accept;
    end
  end

  assign bus.busy    = 1'b0;
  assign bus.done    = done_q;
  assign bus.collide = 1'b0;

`endif

endmodule

// File: tb/tb_snake_body_buffer.sv
// Self-checking bench for snake_body_buffer: directed tables, hand sequences and random steps against a queue model.
module tb_snake_body_buffer;
  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int MAX_LEN  = 16;
  localparam int INIT_LEN = 4;
  localparam int X0       = 39;
  localparam int Y0       = 59;
  localparam int XSTEP    = 10;
  localparam int LW       = $clog2(MAX_LEN + 1);
`ifdef SNAKE_SELF_COLLIDE_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  typedef struct {
    int idx;
    int ex;
    int ey;
  } rd_vec_t;

  typedef struct {
    int hx;
    int hy;
    bit grow;
    int exp_len;
    bit exp_coll;
  } step_vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  snake_body_buffer_if #(.XW(XW), .YW(YW), .LW(LW)) bus ();

  snake_body_buffer #(
    .XW(XW), .YW(YW), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN),
    .X0(X0), .Y0(Y0), .XSTEP(XSTEP), .LW(LW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int mq[$];
  int mlen;
  bit mcoll;

  rd_vec_t   rd_tbl[7];
  step_vec_t st_tbl[16];

  function automatic int coord(input int x, input int y);
    return ((x & 255) << 7) | (y & 127);
  endfunction

  function automatic int exp_rd(input int i);
    return (i < mlen) ? mq[i] : 0;
  endfunction

  function automatic int dut_rd();
    return (int'(bus.rd_x) << 7) | int'(bus.rd_y);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    mq.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      mq.push_back((i < INIT_LEN) ? coord(X0 - i * XSTEP, Y0) : 0);
    end
    mlen  = INIT_LEN;
    mcoll = 1'b0;
  endtask

  task automatic model_step(input int hx, input int hy, input bit g);
    mq.push_front(coord(hx, hy));
    void'(mq.pop_back());
    if (g && mlen < MAX_LEN) mlen++;
    mcoll = 1'b0;
    if (COLL_EN) begin
      for (int i = 1; i < mlen; i++) begin
        if (mq[i] == mq[0]) mcoll = 1'b1;
      end
    end
  endtask

  task automatic read_all();
    for (int i = 0; i <= MAX_LEN; i++) begin
      bus.rd_idx = LW'(i);
      tick();
      check($sformatf("read[%0d]", i), dut_rd(), exp_rd(i));
    end
  endtask

  // One step and its whole scan window; hold keeps step high through SCAN/DONE.
  task automatic do_step(input int hx, input int hy, input bit g, input bit hold);
    int lat;
    int prev;
    bus.step   = 1'b1;
    bus.grow   = g;
    bus.head_x = XW'(hx);
    bus.head_y = YW'(hy);
    tick();
    model_step(hx, hy, g);
    lat  = COLL_EN ? mlen : 1;
    prev = -1;
    if (!hold) bus.step = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      check("busy", int'(bus.busy), int'(COLL_EN && (k < lat)));
      check("done", int'(bus.done), int'(k == lat));
      check("length", int'(bus.length), mlen);
      if (k == 1 || k == lat) check("collide", int'(bus.collide), (k == lat) ? int'(mcoll) : 0);
      if (prev >= 0) check("scan_read", dut_rd(), exp_rd(prev));
      prev = $urandom_range(0, MAX_LEN);
      bus.rd_idx = LW'(prev);
      tick();
    end
    bus.step = 1'b0;
    check("idle_done", int'(bus.done), 0);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_length", int'(bus.length), mlen);
    check("collide_hold", int'(bus.collide), int'(mcoll));
    check("idle_read", dut_rd(), exp_rd(prev));
  endtask

  task automatic check_init_state(input string nm);
    check({nm, "_busy"}, int'(bus.busy), 0);
    check({nm, "_done"}, int'(bus.done), 0);
    check({nm, "_coll"}, int'(bus.collide), 0);
    check({nm, "_len"}, int'(bus.length), INIT_LEN);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    rd_tbl[0] = '{0, 39, 59};
    rd_tbl[1] = '{1, 29, 59};
    rd_tbl[2] = '{2, 19, 59};
    rd_tbl[3] = '{3, 9, 59};
    rd_tbl[4] = '{4, 0, 0};
    rd_tbl[5] = '{15, 0, 0};
    rd_tbl[6] = '{16, 0, 0};
    st_tbl[0] = '{49, 59, 1'b0, 4, 1'b0};
    st_tbl[1] = '{39, 59, 1'b0, 4, COLL_EN};
    for (int i = 0; i < 14; i++) begin
      st_tbl[2 + i] = '{100 + 3 * i, 20, 1'b1, (5 + i > 16) ? 16 : 5 + i, 1'b0};
    end

    reset      = 1'b1;
    bus.init   = 1'b0;
    bus.step   = 1'b0;
    bus.grow   = 1'b0;
    bus.head_x = '0;
    bus.head_y = '0;
    bus.rd_idx = '0;
    tick();
    tick();
    reset = 1'b0;
    model_init();
    check("reset_rd", dut_rd(), 0);
    check_init_state("reset");

    for (int i = 0; i < 7; i++) begin
      bus.rd_idx = LW'(rd_tbl[i].idx);
      tick();
      check($sformatf("rst_x[%0d]", rd_tbl[i].idx), int'(bus.rd_x), rd_tbl[i].ex);
      check($sformatf("rst_y[%0d]", rd_tbl[i].idx), int'(bus.rd_y), rd_tbl[i].ey);
    end

    for (int i = 0; i < 16; i++) begin
      do_step(st_tbl[i].hx, st_tbl[i].hy, st_tbl[i].grow, 1'b0);
      check($sformatf("tbl_len[%0d]", i), int'(bus.length), st_tbl[i].exp_len);
      check($sformatf("tbl_coll[%0d]", i), int'(bus.collide), int'(st_tbl[i].exp_coll));
      if (i < 2) read_all();
    end
    read_all();

`ifdef SNAKE_SELF_COLLIDE_EN
    do_step(7, 7, 1'b0, 1'b1);
    read_all();
`endif

    // Init in the middle of a scan.
    bus.step   = 1'b1;
    bus.grow   = 1'b0;
    bus.head_x = XW'(200);
    bus.head_y = YW'(3);
    tick();
    model_step(200, 3, 1'b0);
    bus.step = 1'b0;
    tick();
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
    model_init();
    for (int k = 0; k < 5; k++) begin
      check_init_state("abort");
      tick();
    end
    read_all();

    // Init and step in the same cycle.
    bus.init   = 1'b1;
    bus.step   = 1'b1;
    bus.grow   = 1'b1;
    bus.head_x = XW'(1);
    bus.head_y = YW'(1);
    tick();
    bus.init = 1'b0;
    bus.step = 1'b0;
    check_init_state("init_step");
    tick();
    check_init_state("init_step2");
    read_all();

    for (int n = 0; n < 60; n++) begin
      if (n % 20 == 19) begin
        if (n == 39) reset = 1'b1;
        else bus.init = 1'b1;
        tick();
        reset    = 1'b0;
        bus.init = 1'b0;
        model_init();
        check_init_state("rnd_init");
      end else begin
        do_step(X0 - int'($urandom_range(0, 4)) * XSTEP + 10, 58 + int'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, 1'b0);
      end
    end
    read_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
